// File: rtl/counter_sequencer.sv
// Sequencer that drives one 4-bit up/down counter from a single command
// (clear, preset, step count, direction) and checks it against a shadow copy.
module counter_sequencer #(
    parameter int STEP_W = 8
) (
    input  logic              CLK,
    input  logic              MR,
    input  logic              START,
    input  logic              CMD_CLR,
    input  logic [3:0]        CMD_VAL,
    input  logic [STEP_W-1:0] CMD_STEPS,
    input  logic              CMD_DIR,
    output logic              CNT_MR,
    output logic              CNT_LOAD,
    output logic              CNT_EN,
    output logic              CNT_UPDN,
    output logic [3:0]        CNT_D,
    input  logic [3:0]        CNT_Q,
    input  logic              CNT_CO,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [3:0]        WRAPS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_COUNT,
        S_CHECK
    } state_t;

    state_t            state, next;
    logic              dir;
    logic [STEP_W-1:0] steps_left;
    logic [3:0]        shadow;
    logic              accept;
    logic              exp_co;
    logic              mismatch;

    assign accept   = (state == S_IDLE) && START;
    assign exp_co   = dir ? (shadow == 4'hF) : (shadow == 4'h0);
    assign mismatch = ((state == S_COUNT) || (state == S_CHECK)) &&
                      ((CNT_Q != shadow) || ((state == S_COUNT) && (CNT_CO != exp_co)));

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  if (START) next = CMD_CLR ? S_CLR : S_LOAD;
            S_CLR:   next = S_LOAD;
            S_LOAD:  next = (steps_left != '0) ? S_COUNT : S_CHECK;
            // steps_left==1 means this is the last enabled cycle
            S_COUNT: if (steps_left <= STEP_W'(1)) next = S_CHECK;
            S_CHECK: next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // Controls are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            CNT_MR     <= 1'b0;
            CNT_LOAD   <= 1'b0;
            CNT_EN     <= 1'b0;
            CNT_UPDN   <= 1'b0;
            CNT_D      <= 4'h0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            WRAPS      <= 4'h0;
            dir        <= 1'b0;
            steps_left <= '0;
            shadow     <= 4'h0;
        end else begin
            CNT_MR   <= (next == S_CLR);
            CNT_LOAD <= (next == S_LOAD);
            CNT_EN   <= (next == S_COUNT);
            CNT_UPDN <= (next == S_COUNT) && dir;
            BUSY     <= (next != S_IDLE);
            DONE     <= (state == S_CHECK);

            if (accept) begin
                CNT_D      <= CMD_VAL;
                dir        <= CMD_DIR;
                steps_left <= CMD_STEPS;
                ERR        <= 1'b0;
                WRAPS      <= 4'h0;
            end

            if (state == S_LOAD) shadow <= CNT_D;

            if (state == S_COUNT) begin
                shadow <= dir ? shadow + 4'd1 : shadow - 4'd1;
                if (steps_left != '0)            steps_left <= steps_left - STEP_W'(1);
                if (CNT_CO && (WRAPS != 4'hF))   WRAPS      <= WRAPS + 4'd1;
            end

            if (mismatch) ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit up/down counter,
// with an optional stuck-at fault on the counter's Q[2].
module tb_counter_sequencer;

    logic       CLK = 1'b0;
    logic       MR;
    logic       START;
    logic       CMD_CLR;
    logic [3:0] CMD_VAL;
    logic [7:0] CMD_STEPS;
    logic       CMD_DIR;
    logic       CNT_MR, CNT_LOAD, CNT_EN, CNT_UPDN;
    logic [3:0] CNT_D;
    logic [3:0] CNT_Q;
    logic       CNT_CO;
    logic       BUSY, DONE, ERR;
    logic [3:0] WRAPS;

    logic [3:0] q_raw = 4'h0;
    logic       stuck = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_n, en_n, mr_n, load_n, done_seen;
    logic [3:0] fin_q, first_q;
    logic done_busy;

    always #5 CLK = ~CLK;

    counter_sequencer #(.STEP_W(8)) dut (
        .CLK(CLK), .MR(MR), .START(START), .CMD_CLR(CMD_CLR), .CMD_VAL(CMD_VAL),
        .CMD_STEPS(CMD_STEPS), .CMD_DIR(CMD_DIR), .CNT_MR(CNT_MR), .CNT_LOAD(CNT_LOAD),
        .CNT_EN(CNT_EN), .CNT_UPDN(CNT_UPDN), .CNT_D(CNT_D), .CNT_Q(CNT_Q), .CNT_CO(CNT_CO),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .WRAPS(WRAPS)
    );

    // Counter model: MR over LOAD over EN, not reset by the sequencer's MR.
    always @(posedge CLK) begin
        if (CNT_MR)        q_raw <= 4'h0;
        else if (CNT_LOAD) q_raw <= CNT_D;
        else if (CNT_EN)   q_raw <= CNT_UPDN ? q_raw + 4'd1 : q_raw - 4'd1;
    end
    assign CNT_Q  = stuck ? (q_raw & 4'b1011) : q_raw;
    assign CNT_CO = CNT_EN && ((CNT_UPDN && CNT_Q == 4'hF) || (!CNT_UPDN && CNT_Q == 4'h0));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command (called at a negedge) and watch it until DONE.
    // inj >= 0 pulses a different START at that busy cycle.
    task automatic run_cmd(input logic clr, input logic [3:0] val, input logic [7:0] steps,
                           input logic d, input int inj);
        CMD_CLR = clr; CMD_VAL = val; CMD_STEPS = steps; CMD_DIR = d; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        busy_n = 0; en_n = 0; mr_n = 0; load_n = 0; done_seen = 0;
        first_q = 4'hX; fin_q = 4'hX; done_busy = 1'bX;
        for (int c = 0; c < 600 && done_seen == 0; c++) begin
            if (c == inj) begin
                START = 1'b1; CMD_CLR = 1'b0; CMD_VAL = 4'd2; CMD_STEPS = 8'd7; CMD_DIR = ~d;
            end else begin
                START = 1'b0;
            end
            if (BUSY)     busy_n++;
            if (CNT_MR)   mr_n++;
            if (CNT_LOAD) load_n++;
            if (CNT_EN) begin
                if (en_n == 0) first_q = CNT_Q;
                en_n++;
            end
            if (DONE) begin
                done_seen = 1; fin_q = CNT_Q; done_busy = BUSY;
            end else begin
                @(negedge CLK);
            end
        end
        START = 1'b0;
        check("done_reached", done_seen, 1);
    endtask

    initial begin
        int done_during_rst;
        MR = 1'b0; START = 1'b0; CMD_CLR = 1'b0; CMD_VAL = 4'h0; CMD_STEPS = 8'h0; CMD_DIR = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_outputs", {CNT_MR, CNT_LOAD, CNT_EN, CNT_UPDN, CNT_D, BUSY, DONE, ERR, WRAPS}, 0);
        MR = 1'b1;
        @(negedge CLK);

        // clear + load 3, 5 up
        run_cmd(1'b1, 4'd3, 8'd5, 1'b1, -1);
        check("t1_busy", busy_n, 8);
        check("t1_mr", mr_n, 1);
        check("t1_load", load_n, 1);
        check("t1_en", en_n, 5);
        check("t1_first_q", first_q, 3);
        check("t1_q", fin_q, 8);
        check("t1_wraps", WRAPS, 0);
        check("t1_err", ERR, 0);
        check("t1_done_busy", done_busy, 0);
        @(negedge CLK);
        check("t1_done_pulse", DONE, 0);
        check("t1_err_held", ERR, 0);

        // wrap through 15 -> 0
        run_cmd(1'b0, 4'd14, 8'd4, 1'b1, -1);
        check("t2_busy", busy_n, 6);
        check("t2_mr", mr_n, 0);
        check("t2_first_q", first_q, 14);
        check("t2_q", fin_q, 2);
        check("t2_wraps", WRAPS, 1);
        check("t2_err", ERR, 0);

        // started in the DONE cycle of the previous command
        run_cmd(1'b0, 4'd1, 8'd20, 1'b0, -1);
        check("t3_busy", busy_n, 22);
        check("t3_en", en_n, 20);
        check("t3_q", fin_q, 13);
        check("t3_wraps", WRAPS, 2);
        check("t3_err", ERR, 0);

        // zero steps, extra START during BUSY
        @(negedge CLK);
        run_cmd(1'b1, 4'd9, 8'd0, 1'b1, 1);
        check("t4_busy", busy_n, 3);
        check("t4_en", en_n, 0);
        check("t4_q", fin_q, 9);
        check("t4_cnt_d", CNT_D, 9);
        check("t4_err", ERR, 0);
        repeat (2) @(negedge CLK);
        check("t4_idle_busy", BUSY, 0);

        // faulty counter, then a clean command clears ERR
        stuck = 1'b1;
        run_cmd(1'b0, 4'd4, 8'd3, 1'b1, -1);
        check("t5_err_fault", ERR, 1);
        stuck = 1'b0;
        @(negedge CLK);
        check("t5_err_sticky", ERR, 1);
        run_cmd(1'b0, 4'd2, 8'd2, 1'b1, -1);
        check("t5_q_clean", fin_q, 4);
        check("t5_err_clean", ERR, 0);

        // reset in the middle of a long count
        @(negedge CLK);
        CMD_CLR = 1'b0; CMD_VAL = 4'd0; CMD_STEPS = 8'd200; CMD_DIR = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        check("t6_counting", {BUSY, CNT_EN}, 2'b11);
        #1 MR = 1'b0;
        #1 check("t6_async_reset", {CNT_MR, CNT_LOAD, CNT_EN, CNT_UPDN, CNT_D, BUSY, DONE, ERR, WRAPS}, 0);
        done_during_rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) done_during_rst++;
        end
        check("t6_no_done", done_during_rst, 0);
        MR = 1'b1;
        @(negedge CLK);
        check("t6_post_release_done", DONE, 0);
        run_cmd(1'b0, 4'd5, 8'd1, 1'b1, -1);
        check("t6_busy", busy_n, 3);
        check("t6_q", fin_q, 6);
        check("t6_err", ERR, 0);
        check("t6_wraps", WRAPS, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Control-side master for the 4-bit up/down counter. It takes a single command: optional clear, preset value, step count and direction. From that command it drives the counter's MR/LOAD/EN/UPDN/D controls and sequences the operation. It monitors the counter's Q and CO outputs against an internal shadow model and reports completion, wrap count and any mismatch. It sits between a command source (test controller or higher-level FSM) and one counter instance.

## Interface
- STEP_W, 8, width of the step-count command; max run length 2^STEP_W-1 count cycles
- CLK  in  1  system clock, all state on rising edge
- MR  in  1  asynchronous, active-low reset of this block
- START  in  1  command strobe; sampled only in IDLE
- CMD_CLR  in  1  1 = issue counter clear before load
- CMD_VAL  in  4  preset value loaded into counter
- CMD_STEPS  in  STEP_W  number of count-enabled cycles
- CMD_DIR  in  1  1 = up, 0 = down
- CNT_MR  out  1  to counter: active-high synchronous clear
- CNT_LOAD  out  1  to counter: synchronous parallel load of CNT_D
- CNT_EN  out  1  to counter: count enable
- CNT_UPDN  out  1  to counter: 1 up, 0 down
- CNT_D  out  4  to counter: preset data
- CNT_Q  in  4  from counter: registered count
- CNT_CO  in  1  from counter: carry/borrow, high when EN & ((UPDN & Q==15) | (!UPDN & Q==0))
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  sticky mismatch flag; cleared on accepted START
- WRAPS  out  4  CO events seen in this command, saturating at 15

## Operation
- Counter contract: MR has priority over LOAD, LOAD over EN. All three are synchronous to CLK.
- On accepted START, latch CMD_* and clear ERR and WRAPS.
- States: IDLE, CLR, LOAD, COUNT, CHECK.
- IDLE: all CNT_* controls 0. On START go to CLR if CMD_CLR, else go to LOAD.
- CLR: CNT_MR=1 for one cycle, then go to LOAD.
- LOAD: CNT_LOAD=1, CNT_D=latched VAL for one cycle. Shadow is set to VAL. Go to COUNT if STEPS≠0, else go to CHECK.
- COUNT: CNT_EN=1, CNT_UPDN=DIR for exactly STEPS cycles. A down-counter of steps remaining is used. Shadow steps ±1 mod 16 at each edge, in lockstep with the counter.
- CHECK: controls 0 for one cycle, then go to IDLE and assert DONE.
- CNT_D holds the latched VAL in all states after the first accepted START. It resets to 0.
- Monitor, every cycle in COUNT and CHECK:
  - CNT_Q≠shadow sets ERR.
  - In COUNT, CNT_CO≠expected CO (DIR ? shadow==15 : shadow==0) sets ERR.
- WRAPS increments at each COUNT-state edge where CNT_CO=1, saturating at 15.
- START while BUSY is ignored; the latched command is unchanged.
- Arithmetic: the shadow is 4-bit modulo-16. The step counter is STEP_W bits and never underflows.

## Timing
- Reset (MR low): asynchronous. State goes to IDLE immediately. CNT_MR, CNT_LOAD, CNT_EN, CNT_UPDN, CNT_D, BUSY, DONE, ERR and WRAPS all go to 0. Deassertion takes effect at the next CLK edge.
- Reset mid-operation aborts the command. No DONE is produced. The counter keeps its last value.
- All outputs are registered.
- START sampled at edge E0. BUSY rises after E0 and stays high through CHECK.
- BUSY length = CMD_CLR + 1 + STEPS + 1 cycles.
- DONE is high for the single cycle after CHECK, with BUSY=0. ERR and WRAPS are valid with DONE and held until the next accepted START.
- START coincident with DONE (the first IDLE cycle) is accepted.
- The first COUNT cycle observes CNT_Q==VAL. The CHECK cycle observes the final value VAL±STEPS mod 16.

## Test plan
- CLR=1, VAL=3, STEPS=5, up: CNT_MR, CNT_LOAD, then 5 EN cycles. BUSY lasts 8 cycles. Final Q=8, WRAPS=0, ERR=0, DONE pulses once.
- CLR=0, VAL=14, STEPS=4, up: Q runs 14,15,0,1,2. WRAPS=1, ERR=0, BUSY lasts 6 cycles.
- CLR=0, VAL=1, STEPS=20, down: final Q=13, WRAPS=2, ERR=0.
- CLR=1, VAL=9, STEPS=0: CNT_EN never asserted, Q=9 in CHECK, BUSY lasts 3 cycles. START pulsed during BUSY is ignored.
- Counter model with Q[2] stuck at 0; VAL=4, STEPS=3, up: ERR=1 at DONE. The next clean command clears ERR to 0.
- MR low during COUNT of a VAL=0, STEPS=200 up command: all outputs go to 0 immediately, no DONE. After release, a VAL=5, STEPS=1 up command ends with Q=6, ERR=0.
